spike_classify_seq: RTL and testbench

Run controller for the output-neuron layer of the spiking classifier.
- On each start request it clears the output neurons and enables them for a bounded integration window.
- It detects the first neuron to fire and returns the winning class index, hit flag and latency over a valid/ready result port.
- It sits between the JTAG host-command logic and the array of output neurons.

---
 rtl/spike_classify_pkg.sv | 25 ++
 rtl/spike_first_fire_enc.sv | 32 +++
 rtl/spike_classify_seq.sv | 147 ++++++++++++++
 tb/tb_spike_classify_seq.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spike_classify_pkg.sv
// Shared types, default parameters and width helpers for the spiking classifier run controller.
package spike_classify_pkg;

  localparam int unsigned NUM_OUT_DEF    = 10;
  localparam int unsigned MAX_CYCLES_DEF = 1785;
  localparam int unsigned CLR_CYCLES_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Index width for n classes; never narrower than one bit.
  function automatic int unsigned cw_f(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Width able to hold the value m itself.
  function automatic int unsigned tw_f(input int unsigned m);
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/spike_first_fire_enc.sv
// Lowest-index priority encoder over the neuron fire flags, with any-set flag.
// The multiple-set output exists only when SPIKE_CLASSIFY_TIE_FLAG_EN is defined.
module spike_first_fire_enc
  import spike_classify_pkg::*;
#(
  parameter  int unsigned N  = NUM_OUT_DEF,
  localparam int unsigned IW = cw_f(N)
) (
  input  logic [N-1:0]  fire,
  output logic [IW-1:0] idx,
  output logic          any
`ifdef SPIKE_CLASSIFY_TIE_FLAG_EN
  , output logic        multi
`endif
);

  // Scan from the top down so the lowest set index is written last.
  always_comb begin
    idx = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (fire[i]) idx = IW'(i);
    end
  end

  assign any = |fire;

`ifdef SPIKE_CLASSIFY_TIE_FLAG_EN
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi = |(fire & (fire - N'(1)));
`endif

endmodule

// File: rtl/spike_classify_seq.sv
// Run controller for the output-neuron layer: clear, integrate, report first firing class.
// Optional result_tie output enabled by SPIKE_CLASSIFY_TIE_FLAG_EN.
module spike_classify_seq
  import spike_classify_pkg::*;
#(
  parameter  int unsigned NUM_OUT    = NUM_OUT_DEF,
  parameter  int unsigned MAX_CYCLES = MAX_CYCLES_DEF,
  parameter  int unsigned CLR_CYCLES = CLR_CYCLES_DEF,
  localparam int unsigned CW         = cw_f(NUM_OUT),
  localparam int unsigned TW         = tw_f(MAX_CYCLES)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               neuron_clr,
  output logic               neuron_en,
  input  logic [NUM_OUT-1:0] neuron_fire,
  output logic               result_valid,
  input  logic               result_ready,
  output logic [CW-1:0]      result_class,
  output logic               result_hit,
  output logic [TW-1:0]      result_cycles
`ifdef SPIKE_CLASSIFY_TIE_FLAG_EN
  , output logic             result_tie
`endif
);

  localparam int unsigned KW = tw_f(CLR_CYCLES);

  state_t          state, state_d;
  logic [KW-1:0]   clr_cnt, clr_cnt_d;
  logic [TW-1:0]   run_cnt, run_cnt_d, run_cnt_inc;
  logic [CW-1:0]   class_d;
  logic            hit_d;
  logic [TW-1:0]   cycles_d;
  logic            busy_d, clr_d, en_d, valid_d;
  logic [CW-1:0]   fire_idx;
  logic            fire_any;
`ifdef SPIKE_CLASSIFY_TIE_FLAG_EN
  logic            fire_multi;
  logic            tie_d;
`endif

  spike_first_fire_enc #(
    .N (NUM_OUT)
  ) u_enc (
    .fire  (neuron_fire),
    .idx   (fire_idx),
    .any   (fire_any)
`ifdef SPIKE_CLASSIFY_TIE_FLAG_EN
    , .multi (fire_multi)
`endif
  );

  // Count of the current RUN cycle (first RUN cycle is 1).
  assign run_cnt_inc = run_cnt + TW'(1);

  // Next-state, counters and next values of all registered outputs.
  always_comb begin
    state_d   = state;
    clr_cnt_d = clr_cnt;
    run_cnt_d = run_cnt;
    class_d   = result_class;
    hit_d     = result_hit;
    cycles_d  = result_cycles;
`ifdef SPIKE_CLASSIFY_TIE_FLAG_EN
    tie_d     = result_tie;
`endif

    case (state)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_CLEAR;
          clr_cnt_d = KW'(CLR_CYCLES - 1);
          run_cnt_d = '0;
        end
      end
      ST_CLEAR: begin
        if (clr_cnt == '0) state_d = ST_RUN;
        else               clr_cnt_d = clr_cnt - KW'(1);
      end
      ST_RUN: begin
        run_cnt_d = run_cnt_inc;
        if (fire_any) begin
          state_d  = ST_DONE;
          class_d  = fire_idx;
          hit_d    = 1'b1;
          cycles_d = run_cnt_inc;
`ifdef SPIKE_CLASSIFY_TIE_FLAG_EN
          tie_d    = fire_multi;
`endif
        end else if (run_cnt_inc == TW'(MAX_CYCLES)) begin
          state_d  = ST_DONE;
          class_d  = '0;
          hit_d    = 1'b0;
          cycles_d = TW'(MAX_CYCLES);
`ifdef SPIKE_CLASSIFY_TIE_FLAG_EN
          tie_d    = 1'b0;
`endif
        end
      end
      ST_DONE: begin
        if (result_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d  = (state_d != ST_IDLE);
    clr_d   = (state_d == ST_IDLE) || (state_d == ST_CLEAR);
    en_d    = (state_d == ST_RUN);
    valid_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      clr_cnt       <= '0;
      run_cnt       <= '0;
      busy          <= 1'b0;
      neuron_clr    <= 1'b1;
      neuron_en     <= 1'b0;
      result_valid  <= 1'b0;
      result_class  <= '0;
      result_hit    <= 1'b0;
      result_cycles <= '0;
`ifdef SPIKE_CLASSIFY_TIE_FLAG_EN
      result_tie    <= 1'b0;
`endif
    end else begin
      state         <= state_d;
      clr_cnt       <= clr_cnt_d;
      run_cnt       <= run_cnt_d;
      busy          <= busy_d;
      neuron_clr    <= clr_d;
      neuron_en     <= en_d;
      result_valid  <= valid_d;
      result_class  <= class_d;
      result_hit    <= hit_d;
      result_cycles <= cycles_d;
`ifdef SPIKE_CLASSIFY_TIE_FLAG_EN
      result_tie    <= tie_d;
`endif
    end
  end

endmodule

// File: tb/tb_spike_classify_seq.sv
// Directed self-checking bench for spike_classify_seq (optional SPIKE_CLASSIFY_TIE_FLAG_EN).
module tb_spike_classify_seq;

  localparam int unsigned NUM_OUT    = 10;
  localparam int unsigned MAX_CYCLES = 1785;
  localparam int unsigned CLR_CYCLES = 2;
  localparam int unsigned CW         = 4;
  localparam int unsigned TW         = 11;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic               busy;
  logic               neuron_clr;
  logic               neuron_en;
  logic [NUM_OUT-1:0] neuron_fire;
  logic               result_valid;
  logic               result_ready;
  logic [CW-1:0]      result_class;
  logic               result_hit;
  logic [TW-1:0]      result_cycles;
`ifdef SPIKE_CLASSIFY_TIE_FLAG_EN
  logic               result_tie;
`endif

  int checks = 0;
  int errors = 0;

  spike_classify_seq #(
    .NUM_OUT    (NUM_OUT),
    .MAX_CYCLES (MAX_CYCLES),
    .CLR_CYCLES (CLR_CYCLES)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .busy          (busy),
    .neuron_clr    (neuron_clr),
    .neuron_en     (neuron_en),
    .neuron_fire   (neuron_fire),
    .result_valid  (result_valid),
    .result_ready  (result_ready),
    .result_class  (result_class),
    .result_hit    (result_hit),
    .result_cycles (result_cycles)
`ifdef SPIKE_CLASSIFY_TIE_FLAG_EN
    , .result_tie  (result_tie)
`endif
  );

  always #5 clk = ~clk;

  // Pulse start for one edge; returns at the negedge of the first CLEAR cycle.
  task automatic start_run();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // From the first CLEAR negedge, advance to the negedge of RUN count n.
  task automatic go_count(input int n);
    repeat (CLR_CYCLES) @(negedge clk);
    repeat (n - 1) @(negedge clk);
  endtask

  // One-cycle result handshake from a DONE negedge; returns at the following negedge.
  task automatic accept();
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; neuron_fire = '0; result_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, neuron_clr, neuron_en, result_valid, result_hit} !== 5'b01000 ||
        result_class !== '0 || result_cycles !== '0) begin
      errors++;
      $display("FAIL reset_values: busy=%0b clr=%0b en=%0b valid=%0b hit=%0b class=%0d cycles=%0d, want 0 1 0 0 0 0 0",
               busy, neuron_clr, neuron_en, result_valid, result_hit, result_class, result_cycles);
    end
`ifdef SPIKE_CLASSIFY_TIE_FLAG_EN
    checks++;
    if (result_tie !== 1'b0) begin
      errors++;
      $display("FAIL reset_tie: got %0b want 0", result_tie);
    end
`endif
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int n_clr = 0;
    int n_en  = 0;
    bit seen  = 0;
    start_run();
    for (int i = 0; i < 3000; i++) begin
      if (result_valid) begin seen = 1; break; end
      if (neuron_clr) n_clr++;
      if (neuron_en) n_en++;
      @(negedge clk);
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL timeout_wait: result_valid not seen within 3000 cycles");
    end
    checks++;
    if (n_clr != int'(CLR_CYCLES) || n_en != int'(MAX_CYCLES)) begin
      errors++;
      $display("FAIL timeout_window: clr_cycles=%0d en_cycles=%0d, want %0d %0d",
               n_clr, n_en, CLR_CYCLES, MAX_CYCLES);
    end
    checks++;
    if (result_hit !== 1'b0 || result_class !== 4'd0 || result_cycles !== 11'd1785 ||
        neuron_en !== 1'b0 || neuron_clr !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL timeout_result: hit=%0b class=%0d cycles=%0d en=%0b clr=%0b busy=%0b, want 0 0 1785 0 0 1",
               result_hit, result_class, result_cycles, neuron_en, neuron_clr, busy);
    end
`ifdef SPIKE_CLASSIFY_TIE_FLAG_EN
    checks++;
    if (result_tie !== 1'b0) begin
      errors++;
      $display("FAIL timeout_tie: got %0b want 0", result_tie);
    end
`endif
    accept();
    checks++;
    if (result_valid !== 1'b0 || busy !== 1'b0 || neuron_clr !== 1'b1 || result_cycles !== 11'd1785) begin
      errors++;
      $display("FAIL timeout_release: valid=%0b busy=%0b clr=%0b cycles=%0d, want 0 0 1 1785",
               result_valid, busy, neuron_clr, result_cycles);
    end
  endtask

  // Runs to RUN count n, fires pattern there, checks the DONE result.
  task automatic test_hit(input string name, input int n, input logic [NUM_OUT-1:0] pat,
                          input logic [CW-1:0] exp_class, input logic exp_tie);
    start_run();
    go_count(1);
    checks++;
    if (neuron_en !== 1'b1 || neuron_clr !== 1'b0) begin
      errors++;
      $display("FAIL %s_run_entry: en=%0b clr=%0b, want 1 0", name, neuron_en, neuron_clr);
    end
    repeat (n - 1) @(negedge clk);
    neuron_fire = pat;
    checks++;
    if (result_valid !== 1'b0 || neuron_en !== 1'b1) begin
      errors++;
      $display("FAIL %s_pre_fire: valid=%0b en=%0b, want 0 1", name, result_valid, neuron_en);
    end
    @(negedge clk);
    neuron_fire = '0;
    checks++;
    if (result_valid !== 1'b1 || result_hit !== 1'b1 || result_class !== exp_class ||
        result_cycles !== TW'(n) || neuron_en !== 1'b0) begin
      errors++;
      $display("FAIL %s_result: valid=%0b hit=%0b class=%0d cycles=%0d en=%0b, want 1 1 %0d %0d 0",
               name, result_valid, result_hit, result_class, result_cycles, neuron_en, exp_class, n);
    end
`ifdef SPIKE_CLASSIFY_TIE_FLAG_EN
    checks++;
    if (result_tie !== exp_tie) begin
      errors++;
      $display("FAIL %s_tie: got %0b want %0b", name, result_tie, exp_tie);
    end
`else
    if (exp_tie) begin end
`endif
    accept();
    checks++;
    if (busy !== 1'b0 || result_valid !== 1'b0 || result_class !== exp_class) begin
      errors++;
      $display("FAIL %s_release: busy=%0b valid=%0b class=%0d, want 0 0 %0d",
               name, busy, result_valid, result_class, exp_class);
    end
  endtask

  task automatic test_back_to_back();
    start_run();
    go_count(5);
    neuron_fire = 10'b0010000000;
    @(negedge clk);
    neuron_fire = '0;
    for (int i = 0; i < 20; i++) begin
      start = (i == 10);
      checks++;
      if (result_valid !== 1'b1 || result_class !== 4'd7 || result_cycles !== 11'd5 ||
          result_hit !== 1'b1 || neuron_en !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL backpressure_hold[%0d]: valid=%0b class=%0d cycles=%0d hit=%0b en=%0b busy=%0b, want 1 7 5 1 0 1",
                 i, result_valid, result_class, result_cycles, result_hit, neuron_en, busy);
      end
      @(negedge clk);
    end
    start = 1'b1;
    accept();
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || result_valid !== 1'b0) begin
      errors++;
      $display("FAIL handshake_release: busy=%0b valid=%0b, want 0 0", busy, result_valid);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || neuron_clr !== 1'b1) begin
      errors++;
      $display("FAIL start_dropped: busy=%0b clr=%0b, want 0 1", busy, neuron_clr);
    end
  endtask

  task automatic test_reset_mid_run();
    start_run();
    go_count(100);
    rst = 1'b1;
    #1;
    checks++;
    if (neuron_clr !== 1'b1 || neuron_en !== 1'b0 || busy !== 1'b0 || result_valid !== 1'b0 ||
        result_hit !== 1'b0 || result_cycles !== '0) begin
      errors++;
      $display("FAIL reset_mid_run: clr=%0b en=%0b busy=%0b valid=%0b hit=%0b cycles=%0d, want 1 0 0 0 0 0",
               neuron_clr, neuron_en, busy, result_valid, result_hit, result_cycles);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_hit("after_reset", 3, 10'b0000000100, 4'd2, 1'b0);
  endtask

  task automatic test_sticky_clear();
    neuron_fire = 10'b0000000001;
    start_run();
    for (int i = 0; i < int'(CLR_CYCLES); i++) begin
      checks++;
      if (neuron_clr !== 1'b1 || neuron_en !== 1'b0 || result_valid !== 1'b0) begin
        errors++;
        $display("FAIL sticky_clear[%0d]: clr=%0b en=%0b valid=%0b, want 1 0 0",
                 i, neuron_clr, neuron_en, result_valid);
      end
      @(negedge clk);
    end
    checks++;
    if (neuron_en !== 1'b1 || result_valid !== 1'b0) begin
      errors++;
      $display("FAIL sticky_run1: en=%0b valid=%0b, want 1 0", neuron_en, result_valid);
    end
    @(negedge clk);
    neuron_fire = '0;
    checks++;
    if (result_valid !== 1'b1 || result_hit !== 1'b1 || result_class !== 4'd0 || result_cycles !== 11'd1) begin
      errors++;
      $display("FAIL sticky_result: valid=%0b hit=%0b class=%0d cycles=%0d, want 1 1 0 1",
               result_valid, result_hit, result_class, result_cycles);
    end
    accept();
  endtask

  initial begin
    test_reset();
    test_timeout();
    test_hit("hit37", 37, 10'b0000100000, 4'd5, 1'b0);
    test_hit("tie12", 12, 10'b1000001000, 4'd3, 1'b1);
    test_hit("hit_at_max", int'(MAX_CYCLES), 10'b1000000000, 4'd9, 1'b0);
    test_back_to_back();
    test_reset_mid_run();
    test_sticky_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
